ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Decoupled instruction-fetch front end. It sits directly upstream of the decode stage and replaces the combinational pc/instruction-memory path.
- It issues word-address requests to a variable-latency instruction memory over a req/gnt/rvalid handshake. Returned instructions are buffered with their PC in a small FIFO.
- It presents the FIFO head to decode over a valid/ready handshake.
- A taken branch or jump from execute redirects the fetch PC and flushes all buffered and in-flight instructions.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, byte PC fetched first after reset (word-aligned).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  32  word address = fetch_pc >> 2
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- inst_valid  out  1  FIFO head valid
- inst  out  32  FIFO head instruction
- inst_pc  out  32  byte PC of FIFO head
- inst_ready  in  1  decode consumes head
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new byte PC; bits [1:0] forced to 0
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async) state: state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers=0. Consequently imem_req=1, imem_addr=RESET_PC>>2, inst_valid=0, inst/inst_pc = don't-care (driven 0).
- States:
  - IDLE: no request outstanding.
  - WAIT: one request granted, response pending.
  - DROP: one granted response pending that must be discarded.
- Maximum one outstanding request.
- imem_req = (state==IDLE) && (count<DEPTH) && !redirect. This is combinational from registered state plus redirect.
- imem_addr changes only on grant or redirect. A redirect may withdraw an ungranted request; memory tolerates this.
- Grant (imem_req && imem_gnt): req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^32 wrap), IDLE -> WAIT.
- imem_rvalid is legal no earlier than the cycle after grant, and only once per grant.
- WAIT && rvalid:
  - push {req_pc, imem_rdata} at wr pointer;
  - WAIT -> IDLE;
  - next request issues the following cycle (peak throughput 1 instr / 2 cycles).
- DROP && rvalid: data discarded, no push, DROP -> IDLE.
- rvalid in IDLE is ignored (covers stale responses after reset).
- Pop: inst_valid && inst_ready, which advances the rd pointer.
- inst_valid = (count != 0). inst/inst_pc are read combinationally from the head entry.
- Push and pop in the same cycle: count unchanged.
- Overflow cannot occur, because a request is only issued when count<DEPTH and at most one is in flight.
- Redirect (highest priority, takes effect at the clock edge):
  - count <= 0 and pointers reset; any same-cycle push or pop is cancelled;
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - State update:
    - WAIT -> DROP, unless rvalid arrives that same cycle, in which case -> IDLE;
    - a grant in the same cycle is impossible because req is masked by redirect;
    - DROP stays DROP, unless rvalid arrives that cycle, in which case -> IDLE;
    - IDLE stays IDLE.
  - inst_valid is 0 in the cycle after redirect.
- A redirect while in DROP with no rvalid: fetch_pc is updated and state stays DROP.
- Wrap-around: FIFO pointers wrap modulo DEPTH. fetch_pc wraps at 2^32.
- Async reset mid-operation returns all state to reset values immediately; a pending memory response arriving later is ignored (state IDLE).

Test Plan:
- Reset: assert rst mid-simulation -> imem_req=1, imem_addr=0, inst_valid=0, count=0 with no clock edge required.
- Streaming: gnt same cycle as req, rvalid 2 cycles later with rdata=0x00210820/0x8c010000/0xac010000, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8 with matching inst, no gaps or duplicates.
- Backpressure and full:
  - Setup: inst_ready=0, memory responding every request.
  - Response: count reaches 4 and imem_req drops to 0.
  - Pulse inst_ready one cycle -> count=3, imem_req=1 next cycle, addr=0x4 (PC 0x10).
- Redirect in WAIT: grant PC 0x8, then redirect=1 with redirect_pc=0x23 before rvalid; rvalid(0xDEADBEEF) arrives later.
  - 0xDEADBEEF is never visible.
  - Next request addr=0x8 (PC 0x20); first inst_pc after redirect = 0x20.
  - count=0 on the redirect edge.
- Simultaneous events: count=2, inst_ready=1, rvalid=1 and redirect=1 in the same cycle -> next count=0, state IDLE, fetch_pc=redirect_pc. Same stimulus without redirect -> count stays 2.
- Pointer wrap: stream 10 instructions with alternating inst_ready -> inst_pc strictly 0x0..0x24 in order, count never exceeds 4.

Source files
------------

// File: rtl/ifetch_queue.sv
// Decoupled instruction-fetch front end: one outstanding imem request at a time,
// responses buffered with their PC in a small FIFO feeding decode.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     buf_inst_q [DEPTH];
  logic [31:0]     buf_pc_q   [DEPTH];

  logic grant;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  // Low PC bits are forced to zero on redirect, so they are never consumed.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign inst_valid = (count_q != '0);
  assign imem_req   = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !redirect;
  assign imem_addr  = {2'b00, fetch_pc_q[31:2]};
  assign grant      = imem_req && imem_gnt;
  assign push       = (state_q == WAIT) && imem_rvalid && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign inst       = inst_valid ? buf_inst_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? buf_pc_q[rd_ptr_q]   : '0;
  assign count      = count_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    // A response always retires the outstanding request, even under redirect.
    case (state_q)
      IDLE:    if (grant) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid)   state_d = IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP:    if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage carries no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: behavioural instruction memory, scoreboard of expected
// (pc, inst) pairs checked by an independent monitor, plus directed state checks.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [2:0]  count;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          grant_total = 0;
  int          grant_limit = 0;
  int          lat = 2;
  int          wait_cnt = 0;
  bit          hold_resp = 1'b0;
  bit          poison = 1'b0;
  bit          pend = 1'b0;
  bit          saw_dead = 1'b0;
  logic [31:0] resp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0021_0820;
      32'd1:   return 32'h8c01_0000;
      32'd2:   return poison ? 32'hDEAD_BEEF : 32'hac01_0000;
      default: return 32'hA000_0000 | a;
    endcase
  endfunction

  // Instruction memory: grant while under the limit, respond lat cycles later.
  always begin
    @(negedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_gnt    = (grant_total < grant_limit);
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else if (!hold_resp) begin
        imem_rvalid = 1'b1;
        imem_rdata  = resp_data;
        pend        = 1'b0;
      end
    end
    #1;
    if (!rst && imem_req && imem_gnt) begin
      pend        = 1'b1;
      wait_cnt    = lat - 1;
      resp_data   = word(imem_addr);
      grant_total++;
    end
  end

  // Monitor: every accepted instruction must match the scoreboard head.
  always begin
    exp_t e;
    int   depth;
    @(negedge clk);
    #2;
    if (!rst && inst_valid && inst == 32'hDEAD_BEEF) saw_dead = 1'b1;
    if (!rst && !redirect && inst_valid && inst_ready) begin
      depth = exp_q.size();
      check("sb_nonempty_at_pop", 32'(depth != 0), 32'd1);
      if (depth != 0) begin
        e = exp_q.pop_front();
        check("pop_inst_pc", inst_pc, e.pc);
        check("pop_inst", inst, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit over;

    // Reset values, no clock edge needed
    #1 rst = 1'b1;
    #1;
    check("reset_req", 32'(imem_req), 32'd1);
    check("reset_addr", imem_addr, 32'd0);
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming, decode always ready
    exp_push(32'h0, 32'h0021_0820);
    exp_push(32'h4, 32'h8c01_0000);
    exp_push(32'h8, 32'hac01_0000);
    inst_ready  = 1'b1;
    grant_limit = 3;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin @(negedge clk); #3; k++; end
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #3;
    check("stream_count", 32'(count), 32'd0);
    check("stream_next_addr", imem_addr, 32'd3);

    // Backpressure to full, then a single pop
    @(negedge clk);
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    redirect = 1'b0;
    exp_push(32'h0,  32'h0021_0820);
    exp_push(32'h4,  32'h8c01_0000);
    exp_push(32'h8,  32'hac01_0000);
    exp_push(32'hC,  32'hA000_0003);
    exp_push(32'h10, 32'hA000_0004);
    grant_limit = grant_total + 5;
    k = 0;
    while (count != 3'd4 && k < 100) begin @(negedge clk); #3; k++; end
    check("bp_full_count", 32'(count), 32'd4);
    check("bp_full_req", 32'(imem_req), 32'd0);
    repeat (3) @(negedge clk);
    #3;
    check("bp_hold_count", 32'(count), 32'd4);
    check("bp_hold_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    #3;
    check("bp_pop_count", 32'(count), 32'd3);
    check("bp_pop_req", 32'(imem_req), 32'd1);
    check("bp_pop_addr", imem_addr, 32'd4);
    k = 0;
    while (count != 3'd4 && k < 100) begin @(negedge clk); #3; k++; end
    check("bp_refill_count", 32'(count), 32'd4);

    // Asynchronous reset while full
    @(negedge clk);
    grant_limit = grant_total;
    #3 rst = 1'b1;
    #1;
    check("midrst_req", 32'(imem_req), 32'd1);
    check("midrst_addr", imem_addr, 32'd0);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Redirect while the request for PC 0x8 is outstanding
    poison     = 1'b1;
    inst_ready = 1'b1;
    exp_push(32'h0, 32'h0021_0820);
    exp_push(32'h4, 32'h8c01_0000);
    grant_limit = grant_total + 3;
    k = 0;
    while (grant_total < grant_limit && k < 100) begin @(negedge clk); #3; k++; end
    check("rd_grants_issued", 32'(grant_total), 32'(grant_limit));
    @(negedge clk);
    hold_resp   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h23;
    #3;
    check("rd_req_masked", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #3;
    check("rd_count", 32'(count), 32'd0);
    check("rd_valid", 32'(inst_valid), 32'd0);
    check("rd_req_in_drop", 32'(imem_req), 32'd0);
    check("rd_addr", imem_addr, 32'd8);
    repeat (2) @(negedge clk);
    #3;
    check("rd_drop_wait_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    hold_resp = 1'b0;
    exp_push(32'h20, 32'hA000_0008);
    exp_push(32'h24, 32'hA000_0009);
    grant_limit = grant_total + 2;
    @(negedge clk); #3;
    check("rd_restart_req", 32'(imem_req), 32'd1);
    check("rd_restart_addr", imem_addr, 32'd8);
    poison = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin @(negedge clk); #3; k++; end
    check("rd_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #3;
    check("rd_no_deadbeef", 32'(saw_dead), 32'd0);
    check("rd_end_count", 32'(count), 32'd0);

    // Push and pop together with count=2, first without then with redirect
    @(negedge clk);
    inst_ready = 1'b0;
    exp_push(32'h28, 32'hA000_000A);
    exp_push(32'h2C, 32'hA000_000B);
    grant_limit = grant_total + 2;
    k = 0;
    while (count != 3'd2 && k < 100) begin @(negedge clk); #3; k++; end
    check("sim_fill_count", 32'(count), 32'd2);
    @(negedge clk);
    exp_push(32'h30, 32'hA000_000C);
    grant_limit = grant_total + 1;
    hold_resp   = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    hold_resp  = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready  = 1'b0;
    grant_limit = grant_total + 1;
    hold_resp   = 1'b1;
    #3;
    check("sim_pushpop_count", 32'(count), 32'd2);
    check("sim_pushpop_valid", 32'(inst_valid), 32'd1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    hold_resp   = 1'b0;
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    exp_q.delete();
    @(negedge clk);
    redirect   = 1'b0;
    inst_ready = 1'b0;
    #3;
    check("sim_redir_count", 32'(count), 32'd0);
    check("sim_redir_valid", 32'(inst_valid), 32'd0);
    check("sim_redir_req_idle", 32'(imem_req), 32'd1);
    check("sim_redir_addr", imem_addr, 32'h40);

    // Ten instructions through the FIFO with alternating ready
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    redirect = 1'b0;
    lat      = 1;
    exp_push(32'h0, 32'h0021_0820);
    exp_push(32'h4, 32'h8c01_0000);
    exp_push(32'h8, 32'hac01_0000);
    for (int i = 3; i < 10; i++) exp_push(32'(4 * i), 32'hA000_0000 + 32'(i));
    grant_limit = grant_total + 10;
    over = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      inst_ready = ~inst_ready;
      #3;
      if (count > 3'd4) over = 1'b1;
      k++;
    end
    check("wrap_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    inst_ready = 1'b0;
    #3;
    check("wrap_count_bound", 32'(over), 32'd0);
    check("wrap_end_count", 32'(count), 32'd0);
    check("wrap_next_addr", imem_addr, 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
